// File: rtl/instruction_sequencer.sv
// Round-robin owner of the shared datapath instruction bus. Each sub-machine requests the bus, gets a one-cycle
// start pulse, and drives the bus until it pulses done or the watchdog takes the bus back.
module instruction_sequencer #(
    parameter int NUM_SEQ        = 4,
    parameter int INSTR_W        = 21,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_SEQ-1:0]         req_i,
    input  logic [NUM_SEQ-1:0]         done_i,
    input  logic [NUM_SEQ*INSTR_W-1:0] instr_i,
    output logic [NUM_SEQ-1:0]         start_o,
    output logic [NUM_SEQ-1:0]         grant_o,
    output logic [INSTR_W-1:0]         instruction_o,
    output logic                       busy_o,
    output logic                       timeout_o
);
    localparam int PTR_W = $clog2(NUM_SEQ);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_q;
    logic [NUM_SEQ-1:0]   grant_q;
    logic [NUM_SEQ-1:0]   start_q;
    logic [PTR_W-1:0]     rr_ptr_q;
    logic [15:0]          wdog_q;
    logic                 timeout_q;

    logic [PTR_W-1:0]     win_idx_d;
    logic                 win_valid_d;
    logic [PTR_W-1:0]     scan_k;
    logic [INSTR_W-1:0]   instr_d;

    // Scanning from the farthest offset down lets the nearest requester after rr_ptr overwrite the others.
    always_comb begin
        win_idx_d   = '0;
        win_valid_d = 1'b0;
        scan_k      = '0;
        for (int i = NUM_SEQ; i >= 1; i--) begin
            scan_k = PTR_W'((int'(rr_ptr_q) + i) % NUM_SEQ);
            if (req_i[scan_k]) begin
                win_idx_d   = scan_k;
                win_valid_d = 1'b1;
            end
        end
    end

    // grant_q is all zero outside RUN, so the mux collapses to NOP with no extra gating.
    always_comb begin
        instr_d = '0;
        for (int k = 0; k < NUM_SEQ; k++) begin
            if (grant_q[k]) begin
                instr_d = instr_i[k*INSTR_W +: INSTR_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            start_q   <= '0;
            rr_ptr_q  <= PTR_W'(NUM_SEQ - 1);
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    start_q <= '0;
                    if (win_valid_d) begin
                        state_q  <= RUN;
                        grant_q  <= NUM_SEQ'(1) << win_idx_d;
                        start_q  <= NUM_SEQ'(1) << win_idx_d;
                        rr_ptr_q <= win_idx_d;
                        wdog_q   <= '0;
                    end
                end
                RUN: begin
                    start_q <= '0;
                    // Done takes priority over an expiry landing on the same cycle.
                    if (|(done_i & grant_q)) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                    end else if (wdog_q == 16'(TIMEOUT_CYCLES - 1)) begin
                        state_q   <= IDLE;
                        grant_q   <= '0;
                        timeout_q <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    start_q <= '0;
                end
            endcase
        end
    end

    assign start_o       = start_q;
    assign grant_o       = grant_q;
    assign instruction_o = instr_d;
    assign busy_o        = (state_q == RUN);
    assign timeout_o     = timeout_q;
endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: a slot-level model checked every cycle plus hand-computed expectations.
module tb_instruction_sequencer;
  localparam int N  = 4;
  localparam int W  = 21;
  localparam int TO = 80;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   done = '0;
  logic [N*W-1:0] instr;
  logic [N-1:0]   start_o, grant_o;
  logic [W-1:0]   instruction_o;
  logic           busy_o, timeout_o;

  int checks = 0;
  int failures = 0;

  instruction_sequencer #(.NUM_SEQ(N), .INSTR_W(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .done_i(done), .instr_i(instr),
    .start_o(start_o), .grant_o(grant_o), .instruction_o(instruction_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: which slot owns the bus (-1 = nobody), how many RUN cycles it has had, and the rotation pointer.
  int   m_slot = -1;
  int   m_rr = N - 1;
  int   m_runs = 0;
  bit   m_first = 0;
  bit   m_to = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_slot = -1; m_rr = N - 1; m_runs = 0; m_first = 0; m_to = 0;
    end else if (m_slot < 0) begin
      for (int off = 1; off <= N; off++) begin
        if (m_slot < 0 && req[(m_rr + off) % N]) begin
          m_slot = (m_rr + off) % N;
        end
      end
      if (m_slot >= 0) begin
        m_rr = m_slot; m_runs = 0; m_first = 1;
      end
    end else begin
      m_first = 0;
      m_runs++;
      if (done[m_slot]) m_slot = -1;
      else if (m_runs == TO) begin
        m_to = 1; m_slot = -1;
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] eg;
    logic [W-1:0] ei;
    #2;
    eg = (m_slot >= 0) ? (N'(1) << m_slot) : '0;
    ei = (m_slot >= 0) ? instr[m_slot*W +: W] : '0;
    check("model_grant", grant_o, eg);
    check("model_start", start_o, m_first ? eg : '0);
    check("model_instr", instruction_o, ei);
    check("model_busy", busy_o, m_slot >= 0);
    check("model_timeout", timeout_o, m_to);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(); rst = 1'b1; req = '0; done = '0;
    step(); rst = 1'b0;
  endtask

  // Waits (bounded) for a start pulse and checks slot and request-to-start latency.
  task automatic wait_grant(input int exp_slot, input int exp_wait, input string name);
    int waited = 0;
    bit found = 0;
    while (!found && waited < 8) begin
      step(); #3; waited++;
      if (start_o != '0) found = 1;
    end
    check({name, "_found"}, found, 1);
    check({name, "_start"}, start_o, N'(1) << exp_slot);
    check({name, "_wait"}, waited, exp_wait);
  endtask

  initial begin
    int fwd;
    int run_cnt;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    instr = {21'h1FFFF, 21'h00018, 21'h0A5A5, 21'h10001};

    // Reset state and first grant
    step(); #3;
    check("rst_grant", grant_o, 0); check("rst_start", start_o, 0);
    check("rst_instr", instruction_o, 0); check("rst_busy", busy_o, 0);
    check("rst_timeout", timeout_o, 0);
    step(); rst = 1'b0; req = 4'b0100; #3;
    check("idle_nop", instruction_o, 0);

    // Forwarding for 64 cycles, done on the 64th, then NOP
    fwd = 0;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (i == 1) req = '0;
      if (i == 64) done = 4'b0100;
      #3;
      if (i == 1) begin
        check("t1_start", start_o, 4'b0100); check("t1_grant", grant_o, 4'b0100);
        check("t1_busy", busy_o, 1);
      end
      if (instruction_o == 21'h00018) fwd++;
    end
    check("fwd_cycles", fwd, 64);
    step(); done = '0; #3;
    check("fwd_nop", instruction_o, 0); check("fwd_idle", busy_o, 0);

    // Round robin with all slots requesting
    do_reset(); req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_grant(exp_order[g], 1, "rr");
      check("rr_instr", instruction_o, instr[exp_order[g]*W +: W]);
      step();
      step(); done = N'(1) << exp_order[g];
      step(); done = '0; #3;
      check("rr_gap_grant", grant_o, 0); check("rr_gap_nop", instruction_o, 0);
    end

    // Watchdog: slot 0 never finishes
    do_reset(); req = 4'b0001;
    wait_grant(0, 1, "wd");
    run_cnt = 1;
    for (int c = 2; c <= TO; c++) begin
      step(); req = '0; #3;
      if (busy_o) run_cnt++;
    end
    check("wd_run_cycles", run_cnt, TO);
    step(); req = 4'b1001; #3;
    check("wd_idle", busy_o, 0); check("wd_timeout", timeout_o, 1); check("wd_grant0", grant_o, 0);
    step(); #3;
    check("wd_next_grant", grant_o, 4'b1000); check("wd_sticky", timeout_o, 1);
    step(); req = '0; done = 4'b1000;
    step(); done = '0; #3;
    check("wd_sticky2", timeout_o, 1);

    // Spurious done and done colliding with expiry
    do_reset(); req = 4'b0010;
    wait_grant(1, 1, "col");
    for (int c = 2; c <= TO; c++) begin
      step();
      if (c == 2) req = '0;
      if (c == 5) done = 4'b1000;
      if (c == 6) done = '0;
      if (c == TO) done = 4'b0010;
      #3;
      if (c == 6) begin
        check("spur_busy", busy_o, 1); check("spur_grant", grant_o, 4'b0010);
      end
    end
    step(); done = '0; #3;
    check("col_idle", busy_o, 0); check("col_no_timeout", timeout_o, 0);

    // Reset in the middle of RUN
    do_reset(); req = 4'b0100;
    wait_grant(2, 1, "mr");
    for (int c = 2; c <= 10; c++) begin
      step();
      if (c == 2) req = '0;
      if (c == 10) rst = 1'b1;
      #3;
    end
    step(); rst = 1'b0; req = 4'b1111; #3;
    check("mr_grant", grant_o, 0); check("mr_instr", instruction_o, 0);
    check("mr_busy", busy_o, 0); check("mr_start", start_o, 0);
    step(); #3;
    check("mr_slot0_first", grant_o, 4'b0001);
    step(); req = '0; done = 4'b0001;
    step(); done = '0;
    step(); #3;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
